// File: rtl/ifm_window_feeder.sv
// Purpose: holds a 3x3 kernel and bias, turns a raster pixel stream into sliding 3x3 windows for the PE array.
// Latency: a window completed by the pixel accepted at edge t is presented with ready_load during cycle t+1.
// Backpressure: pix_ready is high only while streaming; the output side is a strobe with no stall input.
module ifm_window_feeder #(
    parameter int INPUT_IFM_WIDTH  = 8,
    parameter int INPUT_WGT_WIDTH  = 8,
    parameter int INPUT_BIAS_WIDTH = 32,
    parameter int PE_ARR_SIZE      = 9,
    parameter int IMG_WIDTH        = 28,
    parameter int IMG_HEIGHT       = 28
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic signed [INPUT_BIAS_WIDTH-1:0] bias_input,
    input  logic                               wgt_valid,
    input  logic signed [INPUT_WGT_WIDTH-1:0]  wgt_data,
    input  logic                               pix_valid,
    input  logic signed [INPUT_IFM_WIDTH-1:0]  pix_data,
    output logic                               pix_ready,
    output logic                               busy,
    output logic                               ready_load,
    output logic signed [INPUT_IFM_WIDTH-1:0]  ifm_output [PE_ARR_SIZE],
    output logic signed [INPUT_WGT_WIDTH-1:0]  wgt_output [PE_ARR_SIZE],
    output logic signed [INPUT_BIAS_WIDTH-1:0] bias_output,
    output logic                               frame_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_WGT = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t state, state_nxt;
    logic [3:0]    wgt_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // line buffer 0 holds the previous row, line buffer 1 the row before it
    logic signed [INPUT_IFM_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic signed [INPUT_IFM_WIDTH-1:0] lb1 [IMG_WIDTH];

    // running window shifts on every accepted pixel; ifm_output only takes complete windows
    logic signed [INPUT_IFM_WIDTH-1:0] win     [PE_ARR_SIZE];
    logic signed [INPUT_IFM_WIDTH-1:0] win_nxt [PE_ARR_SIZE];

    logic accept;
    logic win_done;
    logic last_pix;
    logic wgt_last;

    assign accept   = pix_ready && pix_valid;
    assign win_done = accept && (row >= ROW_TWO) && (col >= COL_TWO);
    assign last_pix = accept && (row == ROW_LAST) && (col == COL_LAST);
    assign wgt_last = (state == LOAD_WGT) && wgt_valid && (wgt_cnt == 4'd8);

    // next-state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD_WGT;
            end
            LOAD_WGT: begin
                if (wgt_last) state_nxt = STREAM;
            end
            STREAM: begin
                pix_ready = 1'b1;
                if (last_pix) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // window after shifting left and inserting the new column (oldest row on top)
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[3*r]     = win[3*r+1];
            win_nxt[3*r + 1] = win[3*r+2];
        end
        win_nxt[2] = lb1[col];
        win_nxt[5] = lb0[col];
        win_nxt[8] = pix_data;
    end

    // state, counters, kernel/bias registers and window output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            wgt_cnt     <= '0;
            col         <= '0;
            row         <= '0;
            ready_load  <= 1'b0;
            bias_output <= '0;
            for (int k = 0; k < PE_ARR_SIZE; k++) begin
                wgt_output[k] <= '0;
                ifm_output[k] <= '0;
                win[k]        <= '0;
            end
        end else begin
            state      <= state_nxt;
            ready_load <= win_done;
            if (state == IDLE && start) begin
                bias_output <= bias_input;
                wgt_cnt     <= '0;
            end
            if (state == LOAD_WGT && wgt_valid) begin
                wgt_output[wgt_cnt] <= wgt_data;
                wgt_cnt             <= wgt_cnt + 4'd1;
                if (wgt_last) begin
                    col <= '0;
                    row <= '0;
                end
            end
            if (accept) begin
                win <= win_nxt;
                if (win_done) ifm_output <= win_nxt;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // line buffers carry no reset: a flagged window only ever reads rows written this frame
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
        end
    end

endmodule

// File: tb/tb_ifm_window_feeder.sv
module tb_ifm_window_feeder;

    localparam int IW   = 8;
    localparam int WW   = 8;
    localparam int BW   = 32;
    localparam int N    = 9;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 start;
    logic signed [BW-1:0] bias_input;
    logic                 wgt_valid;
    logic signed [WW-1:0] wgt_data;
    logic                 pix_valid;
    logic signed [IW-1:0] pix_data;
    logic                 pix_ready;
    logic                 busy;
    logic                 ready_load;
    logic signed [IW-1:0] ifm_output [N];
    logic signed [WW-1:0] wgt_output [N];
    logic signed [BW-1:0] bias_output;
    logic                 frame_done;

    ifm_window_feeder #(
        .INPUT_IFM_WIDTH (IW),
        .INPUT_WGT_WIDTH (WW),
        .INPUT_BIAS_WIDTH(BW),
        .PE_ARR_SIZE     (N),
        .IMG_WIDTH       (W),
        .IMG_HEIGHT      (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bias_input (bias_input),
        .wgt_valid  (wgt_valid),
        .wgt_data   (wgt_data),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .ready_load (ready_load),
        .ifm_output (ifm_output),
        .wgt_output (wgt_output),
        .bias_output(bias_output),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [N-1:0][IW-1:0] ifm;
        logic [N-1:0][WW-1:0] wgt;
        logic [BW-1:0]        bias;
        logic                 last;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          passes = 0;
    logic [IW-1:0] frm [NPIX];
    logic [WW-1:0] mdl_wgt [N];
    logic [BW-1:0] mdl_bias;
    bit          prev_acc = 1'b0;
    int          win_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // monitor: pops the scoreboard whenever the DUT strobes a window
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0][WW-1:0] wv;
        if (!rst_n) begin
            win_cnt = 0;
        end else begin
            chk("strobe_protocol",
                64'({ready_load && !prev_acc, frame_done && !ready_load, frame_done && (pix_ready || !busy)}),
                64'(0));
            if (ready_load) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_window", 64'(1), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    for (int k = 0; k < N; k++)
                        chk($sformatf("ifm_lane%0d", k), 64'($unsigned(ifm_output[k])), 64'(e.ifm[k]));
                    for (int k = 0; k < N; k++) wv[k] = wgt_output[k];
                    chk("wgt_lanes", 64'(wv[7:0]), 64'(e.wgt[7:0]));
                    chk("wgt_lane8", 64'($unsigned(wgt_output[8])), 64'(e.wgt[8]));
                    chk("bias_output", 64'($unsigned(bias_output)), 64'(e.bias));
                    chk("frame_done_with_last", 64'(frame_done), 64'(e.last));
                    win_cnt++;
                end
            end
            if (frame_done) begin
                chk("window_count", 64'(win_cnt), 64'(NWIN));
                win_cnt = 0;
            end
        end
        prev_acc = rst_n && pix_valid && pix_ready;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic any_nz;
        any_nz = 1'b0;
        for (int k = 0; k < N; k++) any_nz = any_nz | (|ifm_output[k]) | (|wgt_output[k]);
        chk({tag, "_lanes"}, 64'(any_nz), 64'(0));
        chk({tag, "_bias"}, 64'($unsigned(bias_output)), 64'(0));
        chk({tag, "_flags"}, 64'({ready_load, frame_done, pix_ready, busy}), 64'(0));
    endtask

    // reference model: every complete window in raster order, computed from the frame array
    task automatic push_window(input int i);
        exp_t e;
        int r, c;
        r = i / W;
        c = i % W;
        if (r >= 2 && c >= 2) begin
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    e.ifm[3*rr + cc] = frm[(r - 2 + rr) * W + (c - 2 + cc)];
            for (int k = 0; k < N; k++) e.wgt[k] = mdl_wgt[k];
            e.bias = mdl_bias;
            e.last = (i == NPIX - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic fill(input int mode);
        logic [IW-1:0] ext [4];
        ext[0] = 8'h80; ext[1] = 8'h7F; ext[2] = 8'hFF; ext[3] = 8'h01;
        for (int i = 0; i < NPIX; i++) begin
            if (mode == 0)      frm[i] = IW'(i + 1);
            else if (mode == 1) frm[i] = IW'($urandom);
            else                frm[i] = ext[$urandom_range(0, 3)];
        end
    endtask

    task automatic load_kernel(input logic [BW-1:0] b, input bit gaps);
        start      = 1'b1;
        bias_input = b;
        pix_valid  = 1'b1;
        pix_data   = 8'h55;
        step;
        start      = 1'b0;
        bias_input = 32'h1234_5678;
        mdl_bias   = b;
        chk("busy_after_start", 64'({busy, pix_ready}), 64'(2'b10));
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    wgt_valid = 1'b0;
                    wgt_data  = WW'($urandom);
                    step;
                end
            end
            wgt_valid = 1'b1;
            wgt_data  = mdl_wgt[k];
            step;
        end
        wgt_valid = 1'b0;
        pix_valid = 1'b0;
        chk("stream_after_9_beats", 64'(pix_ready), 64'(1));
    endtask

    // gap_mode: 0 back-to-back, 1 alternating, 2 random; abort_at < 0 runs the whole frame
    task automatic stream_frame(input int gap_mode, input int abort_at, input bit poke_start);
        logic any_bad;
        for (int i = 0; i < NPIX; i++) begin
            if (i == abort_at) begin
                pix_valid = 1'b0;
                rst_n     = 1'b0;
                step;
                check_reset_outputs("midframe_reset");
                rst_n = 1'b1;
                return;
            end
            if (i > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))) begin
                pix_valid = 1'b0;
                pix_data  = IW'($urandom);
                step;
            end
            pix_valid = 1'b1;
            pix_data  = frm[i];
            if (poke_start && i == 5) begin
                start      = 1'b1;
                bias_input = 32'hDEAD_BEEF;
            end
            push_window(i);
            step;
            start = 1'b0;
        end
        pix_valid = 1'b0;
        step;
        chk("idle_after_done", 64'({busy, pix_ready}), 64'(0));
        any_bad = 1'b0;
        for (int k = 0; k < N; k++) any_bad = any_bad | (wgt_output[k] !== mdl_wgt[k]);
        chk("kernel_held_in_idle", 64'({any_bad, bias_output !== mdl_bias}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        bias_input = '0;
        wgt_valid  = 1'b0;
        wgt_data   = '0;
        pix_valid  = 1'b0;
        pix_data   = '0;
        step;
        step;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step;

        // 4x4 ramp, kernel 1..9, bias 100
        for (int k = 0; k < N; k++) mdl_wgt[k] = WW'(k + 1);
        fill(0);
        load_kernel(32'd100, 1'b0);
        stream_frame(0, -1, 1'b0);

        // same frame with weight and pixel gaps, plus a start during streaming
        load_kernel(32'd100, 1'b1);
        stream_frame(1, -1, 1'b1);

        // unit kernel, zero bias
        for (int k = 0; k < N; k++) mdl_wgt[k] = 8'd1;
        load_kernel(32'd0, 1'b0);
        stream_frame(0, -1, 1'b0);

        // sign extremes
        for (int k = 0; k < N; k++) mdl_wgt[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
        fill(2);
        load_kernel(32'hFFFF_FF80, 1'b0);
        stream_frame(2, -1, 1'b0);

        // abort after 9 pixels, then a clean frame
        for (int k = 0; k < N; k++) mdl_wgt[k] = WW'($urandom);
        fill(1);
        load_kernel(32'($urandom), 1'b0);
        stream_frame(0, 9, 1'b0);
        step;
        fill(0);
        load_kernel(32'd100, 1'b1);
        stream_frame(0, -1, 1'b0);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) mdl_wgt[k] = WW'($urandom);
            fill(($urandom_range(0, 1) == 0) ? 1 : 2);
            load_kernel(32'($urandom), f[0]);
            stream_frame($urandom_range(0, 2), -1, f[1]);
            repeat ($urandom_range(0, 2)) step;
        end

        repeat (3) step;
        chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
